// File: rtl/sort4_serializer.sv
// Takes one sorted four-value frame and sends it out as a stream, min first and max last.
// Flags any accepted frame whose values are not in nondecreasing order.
module sort4_serializer #(
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     min,
    input  logic [W-1:0]     midl,
    input  logic [W-1:0]     midh,
    input  logic [W-1:0]     max,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             order_err,
    output logic [CNT_W-1:0] frame_cnt
);

    // state | meaning
    // IDLE  | no frame held
    // SEND  | frame held, emitting hold[idx]
    typedef enum logic {IDLE, SEND} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] hold [4];
    logic [1:0]   idx;
    logic         accept;
    logic         xfer;
    logic         last_idx;
    logic         bad_order;

    assign last_idx  = (idx == 2'd3);
    assign out_valid = (state == SEND);
    assign out_last  = out_valid && last_idx;
    assign out_data  = out_valid ? hold[idx] : '0;
    assign xfer      = out_valid && out_ready;
    assign accept    = in_valid && in_ready;
    assign bad_order = (min > midl) || (midl > midh) || (midh > max);

    // When the last element leaves, a new frame can load on the same edge.
    always_comb begin
        in_ready  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = SEND;
            end
            SEND: begin
                in_ready = last_idx && out_ready;
                if (xfer && last_idx && !accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hold[i] <= '0;
            idx       <= 2'd0;
            order_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                hold[0] <= min;
                hold[1] <= midl;
                hold[2] <= midh;
                hold[3] <= max;
                idx     <= 2'd0;
            end else if (xfer) begin
                idx <= idx + 2'd1;
            end
            if (accept && bad_order) order_err <= 1'b1;
            if (xfer && last_idx) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: doc/sort4_serializer.md
SORT4_SERIALIZER -- requirements
Module: sort4_serializer

Interface
REQ-001 SHALL have parameter W, default 2, bit width of each sorted value.
REQ-002 SHALL have parameter CNT_W, default 8, width of the frame counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream sorter presents a sorted frame.
REQ-006 SHALL have port in_ready  output  1  block accepts a frame this cycle.
REQ-007 SHALL have ports min, midl, midh, max  input  W each  sorted values, expected nondecreasing.
REQ-008 SHALL have port out_data  output  W  serialized value.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port out_last  output  1  out_data is the 4th (max) element of the frame.
REQ-012 SHALL have port order_err  output  1  sticky flag; an accepted frame was not nondecreasing.
REQ-013 SHALL have port frame_cnt  output  CNT_W  count of fully transmitted frames.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no frame held) and SEND (frame held, emitting elements).
REQ-015 SHALL define accept as in_valid && in_ready at a rising edge; output transfer as out_valid && out_ready at a rising edge.
REQ-016 SHALL drive in_ready = 1 in IDLE, and in SEND only when idx == 3 && out_ready == 1; otherwise 0.
REQ-017 On accept, SHALL capture min, midl, midh, max into a 4-entry holding register, set idx = 0, enter SEND.
REQ-018 SHALL assert out_valid in SEND only, starting the cycle after the accepting edge (latency 1 clock).
REQ-019 SHALL drive out_data = hold[idx], order min, midl, midh, max (idx 0..3), registered or muxed from registered state only.
REQ-020 SHALL assert out_last exactly when out_valid && idx == 3.
REQ-021 While out_valid && !out_ready, out_data, out_last and idx SHALL hold unchanged.
REQ-022 On transfer with idx < 3, SHALL increment idx.
REQ-023 On transfer with idx == 3 and simultaneous accept, SHALL load the new frame, set idx = 0, remain in SEND (no bubble).
REQ-024 On transfer with idx == 3 and no accept, SHALL return to IDLE; out_valid = 0 next cycle.
REQ-025 SHALL increment frame_cnt by 1 on each transfer with out_last = 1; wrap from 2^CNT_W-1 to 0.
REQ-026 On accept, SHALL set order_err if min > midl or midl > midh or midh > max (unsigned compare); once set it SHALL stay 1 until reset.
REQ-027 A frame flagged by REQ-026 SHALL still be forwarded unchanged.
REQ-028 Input values while in_ready = 0 SHALL be ignored.

Reset
REQ-029 When rst = 1 at a rising edge, SHALL set state IDLE, idx 0, holding register 0, out_valid 0, out_last 0, out_data 0, order_err 0, frame_cnt 0.
REQ-030 rst SHALL override any simultaneous accept or transfer; a frame in progress is discarded with no further output.
REQ-031 in_ready SHALL be 1 the first cycle after rst deasserts.

Verification
REQ-032 Single frame: accept {0,1,2,3}, out_ready=1 -> out_data 0,1,2,3 on 4 consecutive cycles starting 1 clock after accept, out_last on 4th, frame_cnt 0->1, order_err 0.
REQ-033 Backpressure: frame {1,1,2,3}, out_ready low 3 cycles at idx 1 -> out_data holds 1, out_valid stays 1; resumes with 2,3; no value lost or duplicated.
REQ-034 Back-to-back: in_valid held with {0,0,1,1} then {2,2,3,3}, out_ready=1 -> 8 consecutive valid outputs 0,0,1,1,2,2,3,3, no idle cycle, frame_cnt = 2.
REQ-035 Order error: accept {3,0,1,2} -> out_data 3,0,1,2 forwarded, order_err = 1 from the cycle after accept and stays 1 through a following good frame.
REQ-036 Reset mid-frame: rst=1 while idx == 2 -> next cycle out_valid 0, frame_cnt 0, order_err 0, in_ready 1.
REQ-037 Counter wrap: 256 frames transmitted -> frame_cnt reads 0 after the 256th out_last transfer.
